// File: rtl/ff_pkg.sv
// Shared mode and SR-conflict policy codes for the multimode flip-flop bank.
package ff_pkg;

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_SR = 2'b10;
    localparam logic [1:0] MODE_JK = 2'b11;

    localparam int POL_HOLD = 0;
    localparam int POL_SET  = 1;
    localparam int POL_RST  = 2;

endpackage

// File: rtl/multimode_ff_cell.sv
// Next-state logic for one flip-flop bit in D, T, SR or JK mode.
module multimode_ff_cell
    import ff_pkg::*;
#(
    parameter int SR_POLICY = POL_HOLD
) (
    input  logic [1:0] mode,
    input  logic       q,
    input  logic       a,
    input  logic       b,
    input  logic       en,
    output logic       q_next
);

    logic sr_both;

    // Any policy code other than set/reset falls back to hold.
    always_comb begin
        sr_both = q;
        if (SR_POLICY == POL_SET) begin
            sr_both = 1'b1;
        end else if (SR_POLICY == POL_RST) begin
            sr_both = 1'b0;
        end
    end

    always_comb begin
        q_next = q;
        if (en) begin
            case (mode)
                MODE_D: q_next = a;
                MODE_T: q_next = q ^ a;
                MODE_SR: begin
                    case ({a, b})
                        2'b10:   q_next = 1'b1;
                        2'b01:   q_next = 1'b0;
                        2'b11:   q_next = sr_both;
                        default: q_next = q;
                    endcase
                end
                default: begin
                    case ({a, b})
                        2'b10:   q_next = 1'b1;
                        2'b01:   q_next = 1'b0;
                        2'b11:   q_next = ~q;
                        default: q_next = q;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH independent mode-selectable flip-flops with SR conflict flag and
// saturating conflict counter.
module multimode_ff_bank
    import ff_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               SR_POLICY = POL_HOLD,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             conflict,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_d, q_q;
    logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
    logic             conflict_d, conflict_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        multimode_ff_cell #(
            .SR_POLICY(SR_POLICY)
        ) u_cell (
            .mode  (mode),
            .q     (q_q[i]),
            .a     (a[i]),
            .b     (b[i]),
            .en    (en[i]),
            .q_next(q_d[i])
        );
    end

    // Several conflicting bits in one edge still count as a single conflict.
    always_comb begin
        conflict_d = (mode == MODE_SR) && (|(en & a & b));
        err_cnt_d  = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = '0;
        end else if (conflict_d && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q        <= RST_VAL;
            conflict_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            q_q        <= q_d;
            conflict_q <= conflict_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign q        = q_q;
    assign qbar     = ~q_q;
    assign conflict = conflict_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Self-checking bench: three banks (hold/set/reset SR policy) driven in parallel.
`timescale 1ns / 100ps
module tb_multimode_ff_bank;

    localparam int         N   = 3;
    localparam logic [3:0] RV  = 4'b1010;
    localparam int         MAXC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] a = '0, b = '0, en = '0;
    logic       clr_err = 1'b0;

    logic [3:0] q_w    [N];
    logic [3:0] qbar_w [N];
    logic       conf_w [N];
    logic [1:0] cnt_w  [N];

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [3:0] qm [N];
    logic       conf_m;
    int         cnt_m;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        multimode_ff_bank #(
            .WIDTH    (4),
            .SR_POLICY(k),
            .CNT_W    (2),
            .RST_VAL  (RV)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .mode    (mode),
            .a       (a),
            .b       (b),
            .en      (en),
            .clr_err (clr_err),
            .q       (q_w[k]),
            .qbar    (qbar_w[k]),
            .conflict(conf_w[k]),
            .err_cnt (cnt_w[k])
        );
    end

    function automatic logic ref_bit(input int md, input int pol, input logic qv,
                                     input logic av, input logic bv, input logic ev);
        if (!ev) return qv;
        if (md == 0) return av;
        if (md == 1) return av ? !qv : qv;
        if (av && bv) begin
            if (md == 3) return !qv;
            if (pol == 1) return 1'b1;
            if (pol == 2) return 1'b0;
            return qv;
        end
        if (av) return 1'b1;
        if (bv) return 1'b0;
        return qv;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) qm[k] = RV;
        conf_m = 1'b0;
        cnt_m  = 0;
    endtask

    // One rising edge; the model samples the same inputs, outputs settle by the negedge.
    task automatic tick();
        logic hit;
        @(posedge clk);
        hit = 1'b0;
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 4; i++)
                qm[k][i] = ref_bit(int'(mode), k, qm[k][i], a[i], b[i], en[i]);
        for (int i = 0; i < 4; i++)
            if (mode == 2'b10 && en[i] && a[i] && b[i]) hit = 1'b1;
        conf_m = hit;
        if (clr_err) cnt_m = 0;
        else if (hit && cnt_m < MAXC) cnt_m = cnt_m + 1;
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] m, input logic [3:0] av, input logic [3:0] bv,
                         input logic [3:0] ev, input logic c);
        mode = m; a = av; b = bv; en = ev; clr_err = c;
    endtask

    task automatic test_reset();
        drive(2'b00, 4'b0011, 4'b0000, 4'b1111, 1'b0);
        tick();
        drive(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            total++;
            if (q_w[k] !== 4'b1010) begin
                bad++; $display("FAIL reset_q[%0d]: got %b want 1010", k, q_w[k]);
            end
            total++;
            if (qbar_w[k] !== 4'b0101) begin
                bad++; $display("FAIL reset_qbar[%0d]: got %b want 0101", k, qbar_w[k]);
            end
            total++;
            if (conf_w[k] !== 1'b0 || cnt_w[k] !== 2'd0) begin
                bad++;
                $display("FAIL reset_flags[%0d]: got conflict=%b cnt=%0d want 0/0",
                         k, conf_w[k], cnt_w[k]);
            end
        end
        #3;
        rst = 1'b0;
        model_reset();
        tick();
        for (int k = 0; k < N; k++) begin
            total++;
            if (q_w[k] !== 4'b1010) begin
                bad++; $display("FAIL reset_hold[%0d]: got %b want 1010", k, q_w[k]);
            end
        end
    endtask

    task automatic test_d_t();
        logic [3:0] exp_t [2] = '{4'b0101, 4'b0110};
        drive(2'b00, 4'b0000, 4'b0000, 4'b1111, 1'b0);
        tick();
        drive(2'b00, 4'b0110, 4'b1111, 4'b1111, 1'b0);
        tick();
        for (int k = 0; k < N; k++) begin
            total++;
            if (q_w[k] !== 4'b0110) begin
                bad++; $display("FAIL d_mode[%0d]: got %b want 0110", k, q_w[k]);
            end
        end
        drive(2'b01, 4'b0011, 4'b1111, 4'b1111, 1'b0);
        for (int s = 0; s < 2; s++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                total++;
                if (q_w[k] !== exp_t[s] || qbar_w[k] !== ~exp_t[s]) begin
                    bad++;
                    $display("FAIL t_mode[%0d] step %0d: got q=%b qbar=%b want %b", k, s,
                             q_w[k], qbar_w[k], exp_t[s]);
                end
            end
        end
    endtask

    task automatic test_sr();
        logic [3:0] exp_sr [N] = '{4'b1000, 4'b1001, 4'b0000};
        drive(2'b00, 4'b0000, 4'b0000, 4'b1111, 1'b1);
        tick();
        drive(2'b10, 4'b1000, 4'b0000, 4'b1111, 1'b0);
        tick();
        for (int k = 0; k < N; k++) begin
            total++;
            if (q_w[k] !== 4'b1000 || conf_w[k] !== 1'b0) begin
                bad++;
                $display("FAIL sr_set[%0d]: got q=%b conflict=%b want 1000/0", k, q_w[k],
                         conf_w[k]);
            end
        end
        drive(2'b10, 4'b1001, 4'b1001, 4'b1111, 1'b0);
        tick();
        for (int k = 0; k < N; k++) begin
            total++;
            if (q_w[k] !== exp_sr[k]) begin
                bad++; $display("FAIL sr_policy[%0d]: got %b want %b", k, q_w[k], exp_sr[k]);
            end
            total++;
            if (conf_w[k] !== 1'b1 || cnt_w[k] !== 2'd1) begin
                bad++;
                $display("FAIL sr_conflict[%0d]: got conflict=%b cnt=%0d want 1/1", k,
                         conf_w[k], cnt_w[k]);
            end
        end
    endtask

    task automatic test_jk();
        logic [3:0] exp_jk [3] = '{4'b1111, 4'b0000, 4'b1111};
        drive(2'b00, 4'b0000, 4'b0000, 4'b1111, 1'b0);
        tick();
        drive(2'b11, 4'b1111, 4'b1111, 4'b1111, 1'b0);
        for (int s = 0; s < 3; s++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                total++;
                if (q_w[k] !== exp_jk[s] || conf_w[k] !== 1'b0 || cnt_w[k] !== 2'd1) begin
                    bad++;
                    $display("FAIL jk_toggle[%0d] step %0d: got q=%b conf=%b cnt=%0d want %b/0/1",
                             k, s, q_w[k], conf_w[k], cnt_w[k], exp_jk[s]);
                end
            end
        end
    endtask

    task automatic test_saturate();
        int exp_c [5] = '{1, 2, 3, 3, 3};
        drive(2'b00, 4'b0000, 4'b0000, 4'b1111, 1'b1);
        tick();
        drive(2'b10, 4'b0001, 4'b0001, 4'b1111, 1'b0);
        for (int s = 0; s < 5; s++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                total++;
                if (int'(cnt_w[k]) != exp_c[s] || conf_w[k] !== 1'b1) begin
                    bad++;
                    $display("FAIL saturate[%0d] step %0d: got cnt=%0d conf=%b want %0d/1", k,
                             s, cnt_w[k], conf_w[k], exp_c[s]);
                end
            end
        end
        clr_err = 1'b1;
        tick();
        for (int k = 0; k < N; k++) begin
            total++;
            if (cnt_w[k] !== 2'd0 || conf_w[k] !== 1'b1) begin
                bad++;
                $display("FAIL clr_on_conflict[%0d]: got cnt=%0d conf=%b want 0/1", k,
                         cnt_w[k], conf_w[k]);
            end
        end
    endtask

    task automatic test_enable();
        drive(2'b00, 4'b0000, 4'b0000, 4'b1111, 1'b0);
        tick();
        drive(2'b00, 4'b1111, 4'b0000, 4'b0101, 1'b0);
        tick();
        for (int k = 0; k < N; k++) begin
            total++;
            if (q_w[k] !== 4'b0101) begin
                bad++; $display("FAIL enable_d[%0d]: got %b want 0101", k, q_w[k]);
            end
        end
        drive(2'b10, 4'b1010, 4'b1010, 4'b0101, 1'b0);
        tick();
        for (int k = 0; k < N; k++) begin
            total++;
            if (conf_w[k] !== 1'b0 || q_w[k] !== 4'b0101 || cnt_w[k] !== 2'd0) begin
                bad++;
                $display("FAIL masked_conflict[%0d]: got conf=%b q=%b cnt=%0d want 0/0101/0",
                         k, conf_w[k], q_w[k], cnt_w[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                for (int k = 0; k < N; k++) begin
                    total++;
                    if (q_w[k] !== RV) begin
                        bad++; $display("FAIL rand_reset[%0d] cyc %0d: got %b want %b", k, c,
                                        q_w[k], RV);
                    end
                end
                #1;
                rst = 1'b0;
            end
            drive(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
                  $urandom_range(0, 9) == 0);
            tick();
            for (int k = 0; k < N; k++) begin
                total++;
                if (q_w[k] !== qm[k] || qbar_w[k] !== ~qm[k]) begin
                    bad++;
                    $display("FAIL rand_q[%0d] cyc %0d: got q=%b qbar=%b want %b", k, c,
                             q_w[k], qbar_w[k], qm[k]);
                end
                total++;
                if (conf_w[k] !== conf_m || int'(cnt_w[k]) != cnt_m) begin
                    bad++;
                    $display("FAIL rand_err[%0d] cyc %0d: got conf=%b cnt=%0d want %b/%0d", k,
                             c, conf_w[k], cnt_w[k], conf_m, cnt_m);
                end
            end
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        #6 rst = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_d_t();
        test_sr();
        test_jk();
        test_saturate();
        test_enable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
